// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants, stage state encoding and ctrl bit indices
package mips_pkg;

   localparam int MIPS_REG_DATA_W = 32;
   localparam int MIPS_REG_ADDR_W = 5;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   // ID/EX control field
   localparam int IDEX_CTRL_REGDST   = 0;
   localparam int IDEX_CTRL_ALUSRC   = 1;
   localparam int IDEX_CTRL_MEMREAD  = 2;
   localparam int IDEX_CTRL_MEMWRITE = 3;
   localparam int IDEX_CTRL_BRANCH   = 4;
   localparam int IDEX_CTRL_REGWRITE = 5;
   localparam int IDEX_CTRL_MEMTOREG = 6;
   localparam int IDEX_CTRL_W        = 7;

   localparam int EXMEM_CTRL_MEMREAD  = 0;
   localparam int EXMEM_CTRL_MEMWRITE = 1;
   localparam int EXMEM_CTRL_BRANCH   = 2;
   localparam int EXMEM_CTRL_REGWRITE = 3;
   localparam int EXMEM_CTRL_MEMTOREG = 4;
   localparam int EXMEM_CTRL_W        = 5;

   localparam int MEMWB_CTRL_REGWRITE = 0;
   localparam int MEMWB_CTRL_MEMTOREG = 1;
   localparam int MEMWB_CTRL_W        = 2;

   typedef struct packed {
      logic [MIPS_REG_DATA_W-1:0] r_data;
      logic [MIPS_REG_DATA_W-1:0] alu_result;
      logic [MIPS_REG_ADDR_W-1:0] dest;
   } memwb_data_t;

   localparam int MEMWB_DATA_W = $bits(memwb_data_t);

endpackage

// File: rtl/mips_pipe_stage.sv
// rtl/mips_pipe_stage.sv - pipeline boundary register with valid/ready, flush, optional skid slot
module mips_pipe_stage
   import mips_pkg::*;
#(
   parameter int CTRL_W  = 2,
   parameter int DATA_W  = 69,
   parameter int SKID_EN = 1,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [CTRL_W-1:0] r_main_ctrl;
   logic [DATA_W-1:0] r_main_data;
   logic [CTRL_W-1:0] w_skid_ctrl;
   logic [DATA_W-1:0] w_skid_data;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic              w_in_ready;
   logic              w_accept;
   logic              w_drain;
   logic              w_main_from_in;
   logic              w_main_from_skid;

   assign out_valid = (r_state != ST_EMPTY);
   assign w_accept  = in_valid & w_in_ready;
   assign w_drain   = out_valid & out_ready;
   assign in_ready  = w_in_ready;
   assign out_ctrl  = r_main_ctrl & {CTRL_W{out_valid}};
   assign out_data  = r_main_data;
   assign stall_cnt = r_stall_cnt;

   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_ONE;
            ST_ONE: begin
               if (w_accept && !w_drain)
                  w_state_nxt = (SKID_EN != 0) ? ST_TWO : ST_ONE;
               else if (!w_accept && w_drain)
                  w_state_nxt = ST_EMPTY;
            end
            ST_TWO:   if (w_drain) w_state_nxt = ST_ONE;
            default:  w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   // Main slot loads from the input when it is (or is becoming) the head, else from skid.
   assign w_main_from_in   = !flush && w_accept &&
                             ((r_state == ST_EMPTY) || ((r_state == ST_ONE) && w_drain));
   assign w_main_from_skid = !flush && (r_state == ST_TWO) && w_drain;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= ST_EMPTY;
         r_main_ctrl <= '0;
         r_main_data <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (flush) begin
            r_main_ctrl <= '0;
         end else if (w_main_from_in) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
         end else if (w_main_from_skid) begin
            r_main_ctrl <= w_skid_ctrl;
            r_main_data <= w_skid_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         r_stall_cnt <= '0;
      else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}}))
         r_stall_cnt <= r_stall_cnt + 1'b1;
   end

   generate
      if (SKID_EN != 0) begin : g_skid
         logic [CTRL_W-1:0] r_skid_ctrl;
         logic [DATA_W-1:0] r_skid_data;
         logic              r_in_ready;

         // Registered ready keeps out_ready off the upstream combinational path.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               r_skid_ctrl <= '0;
               r_skid_data <= '0;
               r_in_ready  <= 1'b1;
            end else begin
               r_in_ready <= (w_state_nxt != ST_TWO);
               if (flush) begin
                  r_skid_ctrl <= '0;
               end else if ((r_state == ST_ONE) && w_accept && !w_drain) begin
                  r_skid_ctrl <= in_ctrl;
                  r_skid_data <= in_data;
               end
            end
         end

         assign w_skid_ctrl = r_skid_ctrl;
         assign w_skid_data = r_skid_data;
         assign w_in_ready  = r_in_ready;
      end else begin : g_noskid
         assign w_skid_ctrl = '0;
         assign w_skid_data = '0;
         assign w_in_ready  = out_ready | ~out_valid;
      end
   endgenerate

endmodule
